alu_flag_stage: RTL

//  Registered execute-output stage directly downstream of the 32-bit ALU. Each accepted

---
 rtl/alu_flag_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_flag_stage.sv
// Registered execute-output stage: 2-entry valid/ready skid buffer carrying the ALU
// result, plus the architectural NZCV register and a per-transaction branch condition.
module alu_flag_stage #(
    parameter int         WIDTH      = 32,
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_zero,
    input  logic             in_overflow,
    input  logic             in_carry,
    input  logic             in_negative,
    input  logic [2:0]       in_f,
    input  logic             in_set_flags,
    input  logic [2:0]       in_cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_f,
    output logic             out_cond_true,
    output logic             out_illegal,
    output logic [3:0]       flags_q
);

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b001;
    localparam logic [2:0] F_AND = 3'b010;
    localparam logic [2:0] F_OR  = 3'b011;
    localparam logic [2:0] F_SLT = 3'b101;

    localparam logic [2:0] C_AL  = 3'b000;
    localparam logic [2:0] C_EQ  = 3'b001;
    localparam logic [2:0] C_NE  = 3'b010;
    localparam logic [2:0] C_LT  = 3'b011;
    localparam logic [2:0] C_GE  = 3'b100;
    localparam logic [2:0] C_LTU = 3'b101;
    localparam logic [2:0] C_GEU = 3'b110;

    logic             accept;
    logic             emit;
    logic             f_legal;
    logic             f_arith;
    logic             flag_upd;
    logic             cond_new;
    logic [3:0]       flags_in;
    logic [3:0]       flags_src;

    logic             skid_full;
    logic [WIDTH-1:0] skid_result;
    logic [2:0]       skid_f;
    logic             skid_cond;
    logic             skid_illegal;

    // in_ready depends only on skid state, never combinationally on out_ready
    assign in_ready = ~skid_full;
    assign accept   = in_valid & in_ready;
    assign emit     = out_valid & out_ready;

    always_comb begin
        f_legal   = (in_f == F_ADD) || (in_f == F_SUB) || (in_f == F_AND) ||
                    (in_f == F_OR)  || (in_f == F_SLT);
        f_arith   = (in_f == F_ADD) || (in_f == F_SUB);
        // logical ops and SLT do not produce meaningful C/V
        flags_in  = {in_negative, in_zero, in_carry & f_arith, in_overflow & f_arith};
        flag_upd  = accept & in_set_flags & f_legal;
        flags_src = (in_set_flags && f_legal) ? flags_in : flags_q;
        case (in_cond)
            C_AL:    cond_new = 1'b1;
            C_EQ:    cond_new = flags_src[2];
            C_NE:    cond_new = ~flags_src[2];
            C_LT:    cond_new = flags_src[3] ^ flags_src[0];
            C_GE:    cond_new = ~(flags_src[3] ^ flags_src[0]);
            C_LTU:   cond_new = ~flags_src[1];
            C_GEU:   cond_new = flags_src[1];
            default: cond_new = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_f         <= '0;
            out_cond_true <= 1'b0;
            out_illegal   <= 1'b0;
            skid_full     <= 1'b0;
            skid_result   <= '0;
            skid_f        <= '0;
            skid_cond     <= 1'b0;
            skid_illegal  <= 1'b0;
        end else if (emit && skid_full) begin
            // accept cannot coincide here since in_ready is low while skid is full
            out_result    <= skid_result;
            out_f         <= skid_f;
            out_cond_true <= skid_cond;
            out_illegal   <= skid_illegal;
            skid_full     <= 1'b0;
        end else if (accept && (!out_valid || emit)) begin
            out_valid     <= 1'b1;
            out_result    <= in_result;
            out_f         <= in_f;
            out_cond_true <= cond_new;
            out_illegal   <= ~f_legal;
        end else if (accept) begin
            skid_full     <= 1'b1;
            skid_result   <= in_result;
            skid_f        <= in_f;
            skid_cond     <= cond_new;
            skid_illegal  <= ~f_legal;
        end else if (emit) begin
            out_valid     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= FLAG_RESET;
        end else if (flag_upd) begin
            flags_q <= flags_in;
        end
    end

endmodule
